mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-access pipeline stage directly upstream of the write-back unit; holds the MEM/WB pipeline register.
- Takes EX/MEM-stage results and performs loads and stores against a variable-latency data memory using a req/ready handshake.
- Formats load data (byte/half/word, signed/unsigned) and generates store byte enables.
- Asserts stall to the upstream pipeline while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_valid_in  in  1  upstream slot holds a valid instruction.
- mem_alu_out_in  in  32  ALU result; used as effective address for loads/stores.
- mem_store_data_in  in  32  store source (rs2).
- mem_pc4_in  in  32  PC+4, passed through.
- mem_imm_in  in  32  immediate, passed through.
- mem_rd_in  in  5  destination register.
- mem_reg_in_sel_in  in  2  WB data select, passed through.
- mem_mem_reg_in  in  1  WB takes memory data.
- mem_reg_wr_in  in  1  register write enable.
- mem_rd_en_in  in  1  load.
- mem_wr_en_in  in  1  store.
- mem_funct3_in  in  3  access size/sign.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  access complete this cycle; for reads, rdata is valid this cycle.
- dmem_rdata  in  32  read word.
- stall_out  out  1  upstream must hold its inputs.
- wb_valid_out, wb_alu_out_out[32], wb_mem_data_out[32], wb_pc4_out[32], wb_imm_out[32], wb_rd_out[5], wb_reg_in_sel_out[2], wb_mem_reg_out, wb_reg_wr_out, wb_misalign_out  out  registered MEM/WB fields.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every wb_* output=0; stall_out=0; dmem_req=0.
- A reset asserted while in WAIT abandons the access and drops dmem_req immediately.
- Memory op is defined as mem_valid_in & (mem_rd_en_in | mem_wr_en_in).
- If both rd_en and wr_en are set, the access is a store.
- FSM states:
  - IDLE: a memory op drives dmem_req=1 combinationally.
    - If dmem_ready is also 1 in the same cycle: zero-wait completion; the result is captured into WB at the next edge.
    - Otherwise: go to WAIT, with stall_out=1 in that same cycle.
  - WAIT: dmem_req=1 and stall_out=1. Upstream holds all inputs stable, so request fields stay stable.
    - On dmem_ready=1: capture into WB at the edge, return to IDLE, stall_out=0 (combinational).
- Total latency is 1 cycle plus the number of wait cycles.
- Non-memory ops and invalid slots: no request; captured into WB next edge, 1-cycle latency.
- While stall_out=1, the WB register loads a bubble: wb_valid_out=0, wb_reg_wr_out=0, other fields hold.
- Address: dmem_addr={alu[31:2],2'b00}; byte offset off=alu[1:0].
- Store encoding:
  - SB (f3=000): be=4'b0001<<off; wdata=byte replicated x4.
  - SH (f3=001): be=4'b0011<<{off[1],1'b0}; wdata=half replicated x2.
  - SW (f3=010 and all other codes): be=4'b1111; wdata=store data.
  - For loads: dmem_we=0, be=4'b1111.
- Load formatting, applied to dmem_rdata into wb_mem_data_out:
  - LB (000): lane off, sign-extended.
  - LH (001): half selected by off[1], sign-extended.
  - LBU (100): zero-extended byte.
  - LHU (101): zero-extended half.
  - LW (010) and all other codes: full word.
- Non-load instructions: wb_mem_data_out=0.
- Pass-through fields (alu_out, pc4, imm, rd, reg_in_sel, mem_reg, reg_wr) register unchanged.
- wb_reg_wr_out = mem_reg_wr_in & mem_valid_in.

Optional Feature:
- Macro: MEM_MISALIGN_CHK_EN.
- Defined: halfword access with off[0]=1, or word access with off!=0, is misaligned. A misaligned access:
  - issues no dmem_req and does not stall;
  - sets wb_misalign_out=1 and forces wb_reg_wr_out=0 for that instruction.
- Not defined: no check; wb_misalign_out is tied 0; offsets are applied as in the encoding above (word accesses ignore off).

Test Plan:
- LW addr 0x100, dmem_ready=1 same cycle, rdata=0xDEADBEEF -> no stall; next edge wb_mem_data_out=0xDEADBEEF, wb_valid_out=1.
- LB addr 0x103, rdata=0x80123456 -> wb_mem_data_out=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x102, store data 0x1234ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1.
- LW with dmem_ready low 3 cycles -> stall_out high 3 cycles, 3 WB bubbles (wb_reg_wr_out=0), then data captured; stall_out low in the ready cycle.
- rst_n pulled low in WAIT -> dmem_req and stall_out 0 immediately, all wb_* 0, FSM IDLE after release.
- With MEM_MISALIGN_CHK_EN: LW addr 0x101 -> dmem_req stays 0, wb_misalign_out=1, wb_reg_wr_out=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage with req/ready data-memory access and MEM/WB register.
// Optional misaligned-access check enabled by defining MEM_MISALIGN_CHK_EN.
module mem_access_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid_in,
  input  logic [XLEN-1:0]       mem_alu_out_in,
  input  logic [XLEN-1:0]       mem_store_data_in,
  input  logic [XLEN-1:0]       mem_pc4_in,
  input  logic [XLEN-1:0]       mem_imm_in,
  input  logic [REG_ADDR_W-1:0] mem_rd_in,
  input  logic [1:0]            mem_reg_in_sel_in,
  input  logic                  mem_mem_reg_in,
  input  logic                  mem_reg_wr_in,
  input  logic                  mem_rd_en_in,
  input  logic                  mem_wr_en_in,
  input  logic [2:0]            mem_funct3_in,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ready,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  stall_out,
  output logic                  wb_valid_out,
  output logic [XLEN-1:0]       wb_alu_out_out,
  output logic [XLEN-1:0]       wb_mem_data_out,
  output logic [XLEN-1:0]       wb_pc4_out,
  output logic [XLEN-1:0]       wb_imm_out,
  output logic [REG_ADDR_W-1:0] wb_rd_out,
  output logic [1:0]            wb_reg_in_sel_out,
  output logic                  wb_mem_reg_out,
  output logic                  wb_reg_wr_out,
  output logic                  wb_misalign_out
);

  typedef enum logic [0:0] {
    IDLE,
    WAIT
  } state_t;

  state_t state_q, state_d;

  logic       mem_op;
  logic       is_st;
  logic       is_ld;
  logic [1:0] off;
  logic       byte_acc;
  logic       half_acc;
  logic       misalign;
  logic       req_op;
  logic       req_c;
  logic       stall_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [XLEN-1:0] ld_fmt;
  logic [XLEN-1:0] ld_data;

  assign mem_op = mem_valid_in & (mem_rd_en_in | mem_wr_en_in);
  assign is_st  = mem_wr_en_in;
  assign is_ld  = mem_rd_en_in & ~mem_wr_en_in;
  assign off    = mem_alu_out_in[1:0];

  // Loads decode size from funct3[1:0]; stores only from the exact codes.
  assign byte_acc = is_st ? (mem_funct3_in == 3'b000)
                          : (mem_funct3_in[1:0] == 2'b00);
  assign half_acc = is_st ? (mem_funct3_in == 3'b001)
                          : (mem_funct3_in[1:0] == 2'b01);

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = mem_op
    & ((half_acc & off[0])
    | (~byte_acc & ~half_acc & (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign req_op = mem_op & ~misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_op) begin
          req_c = 1'b1;
          if (!dmem_ready) begin
            stall_c = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (dmem_ready) begin
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst_n so an abandoned access drops at once.
  assign dmem_req  = req_c & rst_n;
  assign stall_out = stall_c & rst_n;
  assign dmem_we   = mem_valid_in & is_st;
  assign dmem_addr = {mem_alu_out_in[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = mem_store_data_in;
    if (is_st) begin
      unique case (1'b1)
        (mem_funct3_in == 3'b000): begin
          dmem_be    = 4'b0001 << off;
          dmem_wdata = {4{mem_store_data_in[7:0]}};
        end
        (mem_funct3_in == 3'b001): begin
          dmem_be    = 4'b0011 << {off[1], 1'b0};
          dmem_wdata = {2{mem_store_data_in[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = mem_store_data_in;
        end
      endcase
    end
  end

  assign ld_byte = dmem_rdata[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_fmt = dmem_rdata;
    unique case (mem_funct3_in)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  assign ld_data = (mem_valid_in & is_ld & ~misalign) ? ld_fmt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_out      <= 1'b0;
      wb_alu_out_out    <= '0;
      wb_mem_data_out   <= '0;
      wb_pc4_out        <= '0;
      wb_imm_out        <= '0;
      wb_rd_out         <= '0;
      wb_reg_in_sel_out <= '0;
      wb_mem_reg_out    <= 1'b0;
      wb_reg_wr_out     <= 1'b0;
      wb_misalign_out   <= 1'b0;
    end else if (stall_c) begin
      wb_valid_out  <= 1'b0;
      wb_reg_wr_out <= 1'b0;
    end else begin
      wb_valid_out      <= mem_valid_in;
      wb_alu_out_out    <= mem_alu_out_in;
      wb_mem_data_out   <= ld_data;
      wb_pc4_out        <= mem_pc4_in;
      wb_imm_out        <= mem_imm_in;
      wb_rd_out         <= mem_rd_in;
      wb_reg_in_sel_out <= mem_reg_in_sel_in;
      wb_mem_reg_out    <= mem_mem_reg_in;
      wb_reg_wr_out     <= mem_reg_wr_in & mem_valid_in & ~misalign;
      wb_misalign_out   <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random checks of mem_access_unit
// against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid_in = 1'b0;
  logic [31:0] mem_alu_out_in = '0;
  logic [31:0] mem_store_data_in = '0;
  logic [31:0] mem_pc4_in = '0;
  logic [31:0] mem_imm_in = '0;
  logic [4:0]  mem_rd_in = '0;
  logic [1:0]  mem_reg_in_sel_in = '0;
  logic        mem_mem_reg_in = 1'b0;
  logic        mem_reg_wr_in = 1'b0;
  logic        mem_rd_en_in = 1'b0;
  logic        mem_wr_en_in = 1'b0;
  logic [2:0]  mem_funct3_in = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_out;
  logic        wb_valid_out;
  logic [31:0] wb_alu_out_out;
  logic [31:0] wb_mem_data_out;
  logic [31:0] wb_pc4_out;
  logic [31:0] wb_imm_out;
  logic [4:0]  wb_rd_out;
  logic [1:0]  wb_reg_in_sel_out;
  logic        wb_mem_reg_out;
  logic        wb_reg_wr_out;
  logic        wb_misalign_out;

  mem_access_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_valid_in      (mem_valid_in),
    .mem_alu_out_in    (mem_alu_out_in),
    .mem_store_data_in (mem_store_data_in),
    .mem_pc4_in        (mem_pc4_in),
    .mem_imm_in        (mem_imm_in),
    .mem_rd_in         (mem_rd_in),
    .mem_reg_in_sel_in (mem_reg_in_sel_in),
    .mem_mem_reg_in    (mem_mem_reg_in),
    .mem_reg_wr_in     (mem_reg_wr_in),
    .mem_rd_en_in      (mem_rd_en_in),
    .mem_wr_en_in      (mem_wr_en_in),
    .mem_funct3_in     (mem_funct3_in),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ready        (dmem_ready),
    .dmem_rdata        (dmem_rdata),
    .stall_out         (stall_out),
    .wb_valid_out      (wb_valid_out),
    .wb_alu_out_out    (wb_alu_out_out),
    .wb_mem_data_out   (wb_mem_data_out),
    .wb_pc4_out        (wb_pc4_out),
    .wb_imm_out        (wb_imm_out),
    .wb_rd_out         (wb_rd_out),
    .wb_reg_in_sel_out (wb_reg_in_sel_out),
    .wb_mem_reg_out    (wb_mem_reg_out),
    .wb_reg_wr_out     (wb_reg_wr_out),
    .wb_misalign_out   (wb_misalign_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic        e_valid, e_mreg, e_rwr, e_mis;
  logic [31:0] e_alu, e_md, e_pc4, e_imm;
  logic [4:0]  e_rd;
  logic [1:0]  e_sel;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag);
    chk({tag, ".valid"}, 32'(wb_valid_out), 32'(e_valid));
    chk({tag, ".alu"}, wb_alu_out_out, e_alu);
    chk({tag, ".mdata"}, wb_mem_data_out, e_md);
    chk({tag, ".pc4"}, wb_pc4_out, e_pc4);
    chk({tag, ".imm"}, wb_imm_out, e_imm);
    chk({tag, ".rd"}, 32'(wb_rd_out), 32'(e_rd));
    chk({tag, ".sel"}, 32'(wb_reg_in_sel_out), 32'(e_sel));
    chk({tag, ".mreg"}, 32'(wb_mem_reg_out), 32'(e_mreg));
    chk({tag, ".regwr"}, 32'(wb_reg_wr_out), 32'(e_rwr));
    chk({tag, ".mis"}, 32'(wb_misalign_out), 32'(e_mis));
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] addr,
                                           input logic [31:0] word);
    int o, b, h;
    o = int'(addr % 4);
    b = int'((word >> (8 * o)) & 32'hFF);
    h = int'((word >> (16 * (o / 2))) & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3,
                                        input logic [31:0] addr);
    int o;
    o = int'(addr % 4);
    case (f3)
      3'd0:    return 4'(1 << o);
      3'd1:    return 4'(3 << ((o / 2) * 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3,
                                            input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h01010101;
      3'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic ref_mis(input logic v, input logic rd,
                                   input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a);
`ifdef MEM_MISALIGN_CHK_EN
    int sz;
    if (!(v && (rd || wr))) return 1'b0;
    if (wr) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return (a % sz) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // One instruction: held for waits+1 cycles when it is a memory op.
  task automatic run_op(input string tag, input logic v, input logic rd,
                        input logic wr, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input logic [31:0] rdata, input int waits);
    logic mop, mis, rwr;
    int nw;
    mis = ref_mis(v, rd, wr, f3, alu);
    mop = v && (rd || wr) && !mis;
    nw = mop ? waits : 0;
    rwr = 1'($urandom);
    mem_valid_in      = v;
    mem_rd_en_in      = rd;
    mem_wr_en_in      = wr;
    mem_funct3_in     = f3;
    mem_alu_out_in    = alu;
    mem_store_data_in = sd;
    mem_pc4_in        = $urandom;
    mem_imm_in        = $urandom;
    mem_rd_in         = 5'($urandom);
    mem_reg_in_sel_in = 2'($urandom);
    mem_mem_reg_in    = 1'($urandom);
    mem_reg_wr_in     = rwr;
    for (int k = 0; k <= nw; k++) begin
      dmem_ready = mop ? (k == nw) : 1'($urandom);
      dmem_rdata = (k == nw) ? rdata : $urandom;
      #1;
      chk({tag, ".req"}, 32'(dmem_req), 32'(mop));
      chk({tag, ".stall"}, 32'(stall_out), 32'(mop && k < nw));
      if (mop) begin
        chk({tag, ".addr"}, dmem_addr, alu & 32'hFFFF_FFFC);
        chk({tag, ".we"}, 32'(dmem_we), 32'(wr));
        chk({tag, ".be"}, 32'(dmem_be), wr ? 32'(ref_be(f3, alu)) : 32'hF);
        if (wr) chk({tag, ".wdata"}, dmem_wdata, ref_wdata(f3, sd));
      end
      @(posedge clk);
      #1;
      if (k < nw) begin
        e_valid = 1'b0;
        e_rwr   = 1'b0;
      end else begin
        e_valid = v;
        e_alu   = alu;
        e_md    = (v && rd && !wr && !mis) ? ref_load(f3, alu, rdata) : '0;
        e_pc4   = mem_pc4_in;
        e_imm   = mem_imm_in;
        e_rd    = mem_rd_in;
        e_sel   = mem_reg_in_sel_in;
        e_mreg  = mem_mem_reg_in;
        e_rwr   = rwr && v && !mis;
        e_mis   = mis;
      end
      check_wb(tag);
    end
  endtask

  task automatic zero_model();
    e_valid = 0; e_alu = 0; e_md = 0; e_pc4 = 0; e_imm = 0;
    e_rd = 0; e_sel = 0; e_mreg = 0; e_rwr = 0; e_mis = 0;
  endtask

  initial begin
    zero_model();
    // Reset with a load presented: nothing may be requested.
    mem_valid_in = 1'b1;
    mem_rd_en_in = 1'b1;
    mem_funct3_in = 3'b010;
    #2;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.stall", 32'(stall_out), 32'd0);
    check_wb("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // The cycle after release captured the presented LW with ready=0? No:
    // dmem_ready was 0, so the unit is now waiting; finish it.
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0;
    #1;
    chk("rel.stall", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1;

    run_op("lw0", 1, 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
    chk("lw0.data", wb_mem_data_out, 32'hDEADBEEF);
    run_op("lb", 1, 1, 0, 3'b000, 32'h103, 0, 32'h80123456, 0);
    chk("lb.data", wb_mem_data_out, 32'hFFFFFF80);
    run_op("lbu", 1, 1, 0, 3'b100, 32'h103, 0, 32'h80123456, 1);
    chk("lbu.data", wb_mem_data_out, 32'h00000080);
    run_op("sh", 1, 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0);
    run_op("sb", 1, 0, 1, 3'b000, 32'h201, 32'h000000A5, 0, 2);
    run_op("lh", 1, 1, 0, 3'b001, 32'h102, 0, 32'h8001_7FFF, 0);
    run_op("lhu", 1, 1, 0, 3'b101, 32'h100, 0, 32'h1234_F00D, 0);
    run_op("both", 1, 1, 1, 3'b010, 32'h40, 32'h55AA_0FF0, 32'h1, 0);
    run_op("lw3", 1, 1, 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 3);
    run_op("nop", 1, 0, 0, 3'b010, 32'h1234, 0, 0, 0);
    run_op("inv", 0, 1, 0, 3'b010, 32'h1238, 0, 32'hFFFF, 0);

    // Reset pulled in WAIT abandons the access.
    mem_valid_in = 1'b1;
    mem_rd_en_in = 1'b1;
    mem_wr_en_in = 1'b0;
    mem_funct3_in = 3'b010;
    mem_alu_out_in = 32'h400;
    dmem_ready = 1'b0;
    #1;
    @(posedge clk);
    #1;
    chk("rstw.stall_pre", 32'(stall_out), 32'd1);
    chk("rstw.req_pre", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw.req", 32'(dmem_req), 32'd0);
    chk("rstw.stall", 32'(stall_out), 32'd0);
    zero_model();
    check_wb("rstw");
    #2;
    rst_n = 1'b1;
    run_op("rstw.idle", 1, 0, 0, 3'b000, 32'h8, 0, 0, 0);

`ifdef MEM_MISALIGN_CHK_EN
    run_op("mis", 1, 1, 0, 3'b010, 32'h101, 0, 32'h12345678, 2);
    chk("mis.flag", 32'(wb_misalign_out), 32'd1);
    chk("mis.regwr", 32'(wb_reg_wr_out), 32'd0);
`endif

    for (int i = 0; i < 200; i++) begin
      run_op("rnd", ($urandom % 8) != 0, 1'($urandom), 1'($urandom),
             3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom % 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
